// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the memory-access stage.
package mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the memory-access stage (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store byte enables/replication, misalignment
// detection, and load-data extraction with sign/zero extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  sz_i,
  input  logic        su_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata_i >> {off_i, 3'b000};
    be_o       = 4'b1111;
    wdata_o    = sdata_i;
    ldata_o    = shifted;
    misalign_o = 1'b0;
    case (sz_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = su_i ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o       = 4'b0011 << {off_i[1], 1'b0};
        wdata_o    = {2{sdata_i[15:0]}};
        ldata_o    = su_i ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
        misalign_o = off_i[0];
      end
      // word, and size code 11 which is handled as a word
      default: begin
        misalign_o = |off_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: IDLE/REQ/RESP FSM driving the data-memory bus and a
// registered write-back result. Optional bus timeout under `MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [31:0]         result,
  input  logic [31:0]         Data_store,
  input  logic [6:0]          opcode,
  input  logic                su,
  input  logic [1:0]          whb,
  input  logic [1:0]          wos,
  input  logic [31:0]         PC_4,
  mem_access_unit_if.master   dmem,
  output logic                mem_busy,
  output logic                wb_valid,
  output logic [31:0]         mem_data_MEM,
  output logic [31:0]         result_MEM,
  output logic [31:0]         PC_4_MEM,
  output logic [1:0]          wos_MEM,
  output logic                misalign,
  output logic                bus_err
);

  state_e      state_q, state_d;

  // operands captured on acceptance, used while the bus transaction runs
  logic [31:0] res_q, res_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] sdata_q, sdata_d;
  logic [1:0]  wos_q, wos_d;
  logic [1:0]  sz_q, sz_d;
  logic        su_q, su_d;
  logic        we_q, we_d;

  // write-back outputs, loaded only on entry to RESP
  logic [31:0] res_mem_q, res_mem_d;
  logic [31:0] pc4_mem_q, pc4_mem_d;
  logic [31:0] ldat_mem_q, ldat_mem_d;
  logic [1:0]  wos_mem_q, wos_mem_d;
  logic        mis_q, mis_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic        in_idle;
  logic [1:0]  al_off, al_sz;
  logic        al_su;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;
  logic        al_mis;
  logic        accept_mem;

  // In IDLE the aligner looks at the live EX operands (misalign check);
  // otherwise it works on the captured transaction.
  assign in_idle = (state_q == ST_IDLE);
  assign al_off  = in_idle ? result[1:0] : res_q[1:0];
  assign al_sz   = in_idle ? whb         : sz_q;
  assign al_su   = in_idle ? su          : su_q;

  mem_align u_align (
    .off_i      (al_off),
    .sz_i       (al_sz),
    .su_i       (al_su),
    .sdata_i    (sdata_q),
    .rdata_i    (dmem.dmem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_mis)
  );

  assign accept_mem = in_idle && ex_valid && is_mem_op(opcode) && !al_mis;

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    pc4_d      = pc4_q;
    sdata_d    = sdata_q;
    wos_d      = wos_q;
    sz_d       = sz_q;
    su_d       = su_q;
    we_d       = we_q;
    res_mem_d  = res_mem_q;
    pc4_mem_d  = pc4_mem_q;
    ldat_mem_d = ldat_mem_q;
    wos_mem_d  = wos_mem_q;
    mis_d      = mis_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    berr_d     = berr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          res_d   = result;
          pc4_d   = PC_4;
          wos_d   = wos;
          sz_d    = whb;
          su_d    = su;
          sdata_d = Data_store;
          we_d    = (opcode == OPC_STORE);
          if (accept_mem) begin
            state_d = ST_REQ;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // non-memory op, or a misaligned access that never reaches the bus
            state_d    = ST_RESP;
            res_mem_d  = result;
            pc4_mem_d  = PC_4;
            wos_mem_d  = wos;
            ldat_mem_d = '0;
            mis_d      = is_mem_op(opcode);
`ifdef MEM_TIMEOUT_EN
            berr_d     = 1'b0;
`endif
          end
        end
      end

      ST_REQ: begin
        if (dmem.dmem_ack) begin
          state_d    = ST_RESP;
          res_mem_d  = res_q;
          pc4_mem_d  = pc4_q;
          wos_mem_d  = wos_q;
          ldat_mem_d = we_q ? 32'h0 : al_ldata;
          mis_d      = 1'b0;
`ifdef MEM_TIMEOUT_EN
          berr_d     = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          res_mem_d  = res_q;
          pc4_mem_d  = pc4_q;
          wos_mem_d  = wos_q;
          ldat_mem_d = '0;
          mis_d      = 1'b0;
          berr_d     = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
`endif
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem.dmem_req   = (state_q == ST_REQ);
    dmem.dmem_we    = (state_q == ST_REQ) && we_q;
    dmem.dmem_addr  = '0;
    dmem.dmem_wdata = '0;
    dmem.dmem_be    = '0;
    if (state_q == ST_REQ) begin
      dmem.dmem_addr  = {res_q[ADDR_W-1:2], 2'b00};
      dmem.dmem_wdata = al_wdata;
      dmem.dmem_be    = al_be;
    end
  end

  assign mem_busy     = (state_q == ST_REQ) || accept_mem;
  assign wb_valid     = (state_q == ST_RESP);
  assign result_MEM   = res_mem_q;
  assign PC_4_MEM     = pc4_mem_q;
  assign wos_MEM      = wos_mem_q;
  assign mem_data_MEM = ldat_mem_q;
  assign misalign     = mis_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_err      = berr_q;
`else
  assign bus_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      res_q      <= '0;
      pc4_q      <= '0;
      sdata_q    <= '0;
      wos_q      <= '0;
      sz_q       <= '0;
      su_q       <= 1'b0;
      we_q       <= 1'b0;
      res_mem_q  <= '0;
      pc4_mem_q  <= '0;
      ldat_mem_q <= '0;
      wos_mem_q  <= '0;
      mis_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      berr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      pc4_q      <= pc4_d;
      sdata_q    <= sdata_d;
      wos_q      <= wos_d;
      sz_q       <= sz_d;
      su_q       <= su_d;
      we_q       <= we_d;
      res_mem_q  <= res_mem_d;
      pc4_mem_q  <= pc4_mem_d;
      ldat_mem_q <= ldat_mem_d;
      wos_mem_q  <= wos_mem_d;
      mis_q      <= mis_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      berr_q     <= berr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; timeout case follows MEM_TIMEOUT_EN.
module tb_mem_access_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] result, Data_store, PC_4;
  logic [6:0]  opcode;
  logic        su;
  logic [1:0]  whb, wos;
  logic        mem_busy, wb_valid, misalign, bus_err;
  logic [31:0] mem_data_MEM, result_MEM, PC_4_MEM;
  logic [1:0]  wos_MEM;

  int checks   = 0;
  int failures = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .result       (result),
    .Data_store   (Data_store),
    .opcode       (opcode),
    .su           (su),
    .whb          (whb),
    .wos          (wos),
    .PC_4         (PC_4),
    .dmem         (bus),
    .mem_busy     (mem_busy),
    .wb_valid     (wb_valid),
    .mem_data_MEM (mem_data_MEM),
    .result_MEM   (result_MEM),
    .PC_4_MEM     (PC_4_MEM),
    .wos_MEM      (wos_MEM),
    .misalign     (misalign),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [1:0] sz, input logic s, input logic [1:0] w,
                       input logic [31:0] pc);
    ex_valid   = 1'b1;
    opcode     = op;
    result     = res;
    Data_store = sd;
    whb        = sz;
    su         = s;
    wos        = w;
    PC_4       = pc;
  endtask

  // Aligned load/store: check bus fields through REQ, ack after `waits` extra cycles.
  task automatic do_mem(input string tag, input logic [6:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [1:0] sz, input logic s,
                        input int waits, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data);
    issue(op, addr, sd, sz, s, 2'b01, 32'h44);
    #1 chk({tag, "_busy_idle"}, {31'b0, mem_busy}, 32'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk({tag, "_req"},   {31'b0, bus.dmem_req}, 32'd1);
    chk({tag, "_we"},    {31'b0, bus.dmem_we}, {31'b0, op == OP_STORE});
    chk({tag, "_addr"},  bus.dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"},    {28'b0, bus.dmem_be}, {28'b0, exp_be});
    chk({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
    chk({tag, "_nowb"},  {31'b0, wb_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk({tag, "_req_hold"},  {31'b0, bus.dmem_req}, 32'd1);
      chk({tag, "_busy_req"},  {31'b0, mem_busy}, 32'd1);
      chk({tag, "_addr_hold"}, bus.dmem_addr, {addr[31:2], 2'b00});
    end
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = rdata;
    @(negedge clk);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    chk({tag, "_wb"},     {31'b0, wb_valid}, 32'd1);
    chk({tag, "_data"},   mem_data_MEM, exp_data);
    chk({tag, "_res"},    result_MEM, addr);
    chk({tag, "_mis"},    {31'b0, misalign}, 32'd0);
    chk({tag, "_berr"},   {31'b0, bus_err}, 32'd0);
    chk({tag, "_reqlow"}, {31'b0, bus.dmem_req}, 32'd0);
    @(negedge clk);
    chk({tag, "_wb_pulse"}, {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int guard;
    rst = 1'b0;
    ex_valid = 1'b0; opcode = '0; result = '0; Data_store = '0;
    whb = '0; su = 1'b0; wos = '0; PC_4 = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_wb",   {31'b0, wb_valid}, 32'd0);
    chk("rst_req",  {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_busy", {31'b0, mem_busy}, 32'd0);
    chk("rst_res",  result_MEM, 32'd0);
    chk("rst_data", mem_data_MEM, 32'd0);
    chk("rst_mis",  {31'b0, misalign}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // non-memory op, latency 1
    issue(OP_ALU, 32'h100, 32'h0, 2'b10, 1'b0, 2'b11, 32'h10);
    #1 chk("alu_busy", {31'b0, mem_busy}, 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("alu_wb",   {31'b0, wb_valid}, 32'd1);
    chk("alu_res",  result_MEM, 32'h100);
    chk("alu_pc4",  PC_4_MEM, 32'h10);
    chk("alu_wos",  {30'b0, wos_MEM}, 32'd3);
    chk("alu_data", mem_data_MEM, 32'h0);
    chk("alu_req",  {31'b0, bus.dmem_req}, 32'd0);
    @(negedge clk);
    chk("alu_wb_pulse", {31'b0, wb_valid}, 32'd0);
    chk("alu_res_hold", result_MEM, 32'h100);
    chk("alu_req2",     {31'b0, bus.dmem_req}, 32'd0);

    do_mem("lb_s",  OP_LOAD,  32'h203, 32'h0, 2'b00, 1'b1, 2, 32'h80FF_FF00, 4'b1000, 32'h0, 32'hFFFF_FF80);
    do_mem("sh",    OP_STORE, 32'h102, 32'h1234_ABCD, 2'b01, 1'b0, 0, 32'hFFFF_FFFF, 4'b1100, 32'hABCD_ABCD, 32'h0);
    do_mem("lbu",   OP_LOAD,  32'h201, 32'h0, 2'b00, 1'b0, 1, 32'h0000_9A00, 4'b0010, 32'h0, 32'h0000_009A);
    do_mem("lhu",   OP_LOAD,  32'h002, 32'h0, 2'b01, 1'b0, 0, 32'h8765_4321, 4'b1100, 32'h0, 32'h0000_8765);
    do_mem("lh_s",  OP_LOAD,  32'h000, 32'h0, 2'b01, 1'b1, 0, 32'h0000_F00D, 4'b0011, 32'h0, 32'hFFFF_F00D);
    do_mem("lw",    OP_LOAD,  32'h300, 32'h0, 2'b10, 1'b1, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    do_mem("sb",    OP_STORE, 32'h001, 32'h0000_0055, 2'b00, 1'b0, 0, 32'h0, 4'b0010, 32'h5555_5555, 32'h0);
    do_mem("sw11",  OP_STORE, 32'h404, 32'hCAFE_0123, 2'b11, 1'b0, 0, 32'h0, 4'b1111, 32'hCAFE_0123, 32'h0);

    // misaligned word load: no bus access
    issue(OP_LOAD, 32'h101, 32'h0, 2'b10, 1'b0, 2'b01, 32'h50);
    #1 chk("misw_busy", {31'b0, mem_busy}, 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("misw_req",  {31'b0, bus.dmem_req}, 32'd0);
    chk("misw_wb",   {31'b0, wb_valid}, 32'd1);
    chk("misw_mis",  {31'b0, misalign}, 32'd1);
    chk("misw_data", mem_data_MEM, 32'h0);
    chk("misw_res",  result_MEM, 32'h101);
    @(negedge clk);
    chk("misw_hold", {31'b0, misalign}, 32'd1);

    // misaligned half store: no bus access, no write
    issue(OP_STORE, 32'h003, 32'hFFFF_FFFF, 2'b01, 1'b0, 2'b00, 32'h54);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mish_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("mish_we",  {31'b0, bus.dmem_we}, 32'd0);
    chk("mish_mis", {31'b0, misalign}, 32'd1);
    @(negedge clk);

    // ex_valid held high: ignored in RESP, accepted in the next IDLE
    issue(OP_ALU, 32'hAAAA, 32'h0, 2'b10, 1'b0, 2'b10, 32'h60);
    @(negedge clk);
    chk("b2b_wb1",  {31'b0, wb_valid}, 32'd1);
    chk("b2b_res1", result_MEM, 32'hAAAA);
    chk("b2b_mis1", {31'b0, misalign}, 32'd0);
    result = 32'hBBBB;
    @(negedge clk);
    chk("b2b_gap",  {31'b0, wb_valid}, 32'd0);
    chk("b2b_hold", result_MEM, 32'hAAAA);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b_wb2",  {31'b0, wb_valid}, 32'd1);
    chk("b2b_res2", result_MEM, 32'hBBBB);
    @(negedge clk);

    // reset during REQ, late ack ignored
    issue(OP_LOAD, 32'h400, 32'h0, 2'b10, 1'b0, 2'b10, 32'h70);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rreq_req", {31'b0, bus.dmem_req}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rreq_reqlow", {31'b0, bus.dmem_req}, 32'd0);
    chk("rreq_wb",     {31'b0, wb_valid}, 32'd0);
    chk("rreq_res",    result_MEM, 32'h0);
    chk("rreq_pc4",    PC_4_MEM, 32'h0);
    chk("rreq_wos",    {30'b0, wos_MEM}, 32'd0);
    chk("rreq_busy",   {31'b0, mem_busy}, 32'd0);
    rst = 1'b1;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'h0;
    chk("rreq_late_wb",  {31'b0, wb_valid}, 32'd0);
    chk("rreq_late_req", {31'b0, bus.dmem_req}, 32'd0);
    @(negedge clk);
    chk("rreq_late_wb2", {31'b0, wb_valid}, 32'd0);
    chk("rreq_data",     mem_data_MEM, 32'h0);

`ifdef MEM_TIMEOUT_EN
    issue(OP_LOAD, 32'h500, 32'h0, 2'b10, 1'b0, 2'b00, 32'h80);
    @(negedge clk);
    ex_valid = 1'b0;
    n = 0;
    guard = 0;
    while (!wb_valid && guard < 40) begin
      if (bus.dmem_req) n++;
      guard++;
      @(negedge clk);
    end
    chk("to_wb",     {31'b0, wb_valid}, 32'd1);
    chk("to_cycles", n, 32'd16);
    chk("to_berr",   {31'b0, bus_err}, 32'd1);
    chk("to_data",   mem_data_MEM, 32'h0);
    chk("to_reqlow", {31'b0, bus.dmem_req}, 32'd0);
    @(negedge clk);
`else
    issue(OP_LOAD, 32'h500, 32'h0, 2'b10, 1'b0, 2'b00, 32'h80);
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("nto_req",  {31'b0, bus.dmem_req}, 32'd1);
    chk("nto_wb",   {31'b0, wb_valid}, 32'd0);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("nto_wb2",  {31'b0, wb_valid}, 32'd1);
    chk("nto_data", mem_data_MEM, 32'h1234_5678);
    chk("nto_berr", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access stage of the unpipelined RISC-V core. It consumes EX outputs: result as the address or ALU value, Data_store, su, whb, wos, opcode and PC_4.
- For loads and stores it runs a req/ack transaction on the data-memory port, aligns store data and byte enables, and sign- or zero-extends load data.
- It hands a registered result to write-back.
- It asserts mem_busy so the core stalls while a transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYCLES, 16, maximum REQ cycles before a bus error (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- ex_valid  in  1  EX outputs valid this cycle
- result  in  32  ALU result / effective address
- Data_store  in  32  store data (rs2)
- opcode  in  7  instruction opcode
- su  in  1  1 = signed load, 0 = unsigned
- whb  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- wos  in  2  write-back select, forwarded
- PC_4  in  32  PC+4, forwarded
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address ({result[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  bus completion (one-cycle pulse)
- dmem_rdata  in  32  load data, valid with dmem_ack
- mem_busy  out  1  stall request to core
- wb_valid  out  1  write-back outputs valid (one-cycle pulse)
- mem_data_MEM  out  32  extended load data (0 for non-loads)
- result_MEM  out  32  registered result
- PC_4_MEM  out  32  registered PC_4
- wos_MEM  out  2  registered wos
- misalign  out  1  misaligned access flagged with wb_valid
- bus_err  out  1  timeout flagged with wb_valid (0 without the optional feature)

Behaviour:
- **Reset** (rst==0 at a clk edge): state IDLE; all outputs 0; an in-flight transaction is abandoned; dmem_req is low from the next cycle; a late dmem_ack is ignored.
- **Opcode classes**: LOAD = 7'b0000011, STORE = 7'b0100011; all others are non-memory.
- **FSM states**: IDLE, REQ, RESP. ex_valid is sampled only in IDLE and ignored otherwise.
- **IDLE, ex_valid and non-memory op**: capture result/PC_4/wos and go to RESP. wb_valid is high the next cycle with mem_data_MEM=0. Latency is 1.
- **IDLE, ex_valid and memory op, aligned**: capture address, size, su, data and we, then go to REQ.
- **IDLE, ex_valid and memory op, misaligned** (half with addr[0]=1; word with addr[1:0]!=0): no bus access and no store. Go to RESP with misalign=1 and mem_data_MEM=0.
- **REQ**: dmem_req=1, with dmem_we/addr/wdata/be held stable until dmem_ack is sampled high. On ack, loads latch the extracted data; go to RESP.
- **RESP**: wb_valid=1 for exactly one cycle, then IDLE. Back-to-back ex_valid is accepted in the following IDLE cycle.
- **mem_busy**: high in REQ, and in IDLE when ex_valid with an aligned memory op. Combinational.
- **Byte enables**:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- **Store data**:
  - byte: {4{Data_store[7:0]}}
  - half: {2{Data_store[15:0]}}
  - word: as-is
- **Load extraction**: shift dmem_rdata right by 8*addr[1:0], take 8/16/32 bits, then sign-extend if su=1, else zero-extend.
- **Registered outputs** (result_MEM, PC_4_MEM, wos_MEM, misalign, bus_err, mem_data_MEM) hold their values until the next RESP and change only on entry to RESP.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- **With the macro**: a counter runs in REQ. After TIMEOUT_CYCLES cycles without ack, dmem_req drops and the FSM goes to RESP with bus_err=1 and mem_data_MEM=0. The counter clears on entry to REQ.
- **Without the macro**: no counter; REQ waits indefinitely; bus_err is tied to 0.

Decomposition:
- Shared package mem_pkg holds:
  - OPC_LOAD and OPC_STORE
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD
  - the FSM state enum
- One combinational sub-module, mem_align, computes dmem_be, dmem_wdata, misalign detection and load extraction/extension from (addr[1:0], whb, su, data).

Test Plan:
- Non-memory op 0110011 with result=32'h100, PC_4=32'h10, wos=2'b11 → wb_valid 1 cycle later, result_MEM=32'h100, mem_data_MEM=0, dmem_req never high.
- Load byte signed: addr 32'h203, su=1, ack after 3 cycles with rdata 32'h80FF_FF00 → dmem_addr=32'h200, be=4'b1000, mem_busy high through REQ, mem_data_MEM=32'hFFFF_FF80.
- Store half: addr 32'h102, Data_store=32'h1234_ABCD → dmem_we=1, be=4'b1100, wdata=32'hABCD_ABCD, wb_valid the cycle after ack.
- Misaligned word load at addr 32'h101 → no dmem_req, wb_valid next cycle with misalign=1.
- rst low during REQ, then an ack arrives → dmem_req low after that edge, no wb_valid, all outputs 0.
- With MEM_TIMEOUT_EN and no ack → wb_valid with bus_err=1 after 16 REQ cycles.
